// File: rtl/kronos_types.sv
// Shared Kronos pipeline types and constants.
package kronos_types;

  localparam logic [31:0] FOUR = 32'h4;

  localparam int unsigned FETCH_DEPTH_MIN = 1;
  localparam int unsigned FETCH_DEPTH_PF  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

endpackage

// File: rtl/kronos_fetch_buffer.sv
// Shift-register FIFO of fetched {pc, ir} entries.
// The head is always entry 0, so the output is a plain register.
module kronos_fetch_buffer
  import kronos_types::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pipeIFID_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output pipeIFID_t        head
);

  pipeIFID_t        entries   [DEPTH];
  pipeIFID_t        entries_d [DEPTH];
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_eff;
  logic             push_eff;

  assign head = entries[0];

  // Pop shifts everything toward the head; push lands just past the last live entry.
  always_comb begin
    entries_d = entries;
    count_d   = count;
    pop_eff   = pop && (count != '0);
    push_eff  = push && ((32'(count) < DEPTH) || pop_eff);
    wr_idx    = count - CNT_W'(pop_eff);
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop_eff) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          entries_d[i] = entries[i + 1];
        end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push_eff && (32'(wr_idx) == 32'(i))) begin
          entries_d[i] = push_data;
        end
      end
      count_d = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else begin
      count   <= count_d;
      entries <= entries_d;
    end
  end

endmodule

// File: rtl/kronos_fetch.sv
// Kronos instruction fetch: sequential PC, single-outstanding bus request,
// redirect with in-flight discard. KRONOS_FETCH_PREFETCH_EN selects a 2-deep buffer.
module kronos_fetch
  import kronos_types::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0
)(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr_data,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output pipeIFID_t   fetch,
  output logic        fetch_vld,
  input  logic        fetch_rdy
);

`ifdef KRONOS_FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = FETCH_DEPTH_PF;
`else
  localparam int unsigned DEPTH = FETCH_DEPTH_MIN;
`endif
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc, pc_d;
  logic [31:0]      redir_pc, redir_pc_d;
  logic [31:0]      target;
  logic             req_d;
  logic             discard, discard_d;
  logic             ack, push, pop;
  logic [CNT_W-1:0] count, count_post;
  pipeIFID_t        push_data;

  assign instr_addr = pc;
  assign target     = branch_target & ~32'h3;
  assign ack        = instr_req & instr_ack;
  assign push       = ack & ~discard & ~branch;
  assign pop        = fetch_vld & fetch_rdy;
  assign push_data  = {pc, instr_data};
  assign fetch_vld  = (count != '0);
  assign count_post = branch ? '0 : count + CNT_W'(push) - CNT_W'(pop);

  kronos_fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (branch),
    .count     (count),
    .head      (fetch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= BOOT_ADDR;
      instr_req <= 1'b0;
      discard   <= 1'b0;
      redir_pc  <= '0;
    end else begin
      pc        <= pc_d;
      instr_req <= req_d;
      discard   <= discard_d;
      redir_pc  <= redir_pc_d;
    end
  end

  // A redirect during an unacked request parks the target until the stale ack
  // arrives, so the bus address stays stable for the life of the request.
  always_comb begin
    pc_d       = pc;
    req_d      = instr_req;
    discard_d  = discard;
    redir_pc_d = redir_pc;
    if (branch) begin
      if (instr_req && !instr_ack) begin
        discard_d  = 1'b1;
        redir_pc_d = target;
      end else begin
        pc_d      = target;
        discard_d = 1'b0;
        req_d     = 1'b1;
      end
    end else if (ack) begin
      pc_d      = discard ? redir_pc : pc + FOUR;
      discard_d = 1'b0;
      req_d     = (32'(count_post) < DEPTH);
    end else if (!instr_req) begin
      req_d = (32'(count_post) < DEPTH);
    end
  end

endmodule

// File: tb/tb_kronos_fetch.sv
// Self-checking bench for kronos_fetch against a stream-level reference model.
module tb_kronos_fetch;
  import kronos_types::*;

`ifdef KRONOS_FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] BOOT = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        branch;
  logic [31:0] branch_target;
  pipeIFID_t   fetch;
  logic        fetch_vld;
  logic        fetch_rdy;

  always #5 clk = ~clk;

  kronos_fetch #(.BOOT_ADDR(BOOT)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_addr    (instr_addr),
    .instr_req     (instr_req),
    .instr_ack     (instr_ack),
    .instr_data    (instr_data),
    .branch        (branch),
    .branch_target (branch_target),
    .fetch         (fetch),
    .fetch_vld     (fetch_vld),
    .fetch_rdy     (fetch_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the delivered stream is consecutive words from the last redirect.
  logic [31:0] exp_pc;     // next pc expected at the output
  logic [31:0] fetch_pc;   // next address a useful ack must carry
  logic [31:0] hold_addr;
  int          occ;
  bit          hold_pend;
  bit          stale;
  int          pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc    = BOOT;
    fetch_pc  = BOOT;
    occ       = 0;
    hold_pend = 0;
    stale     = 0;
    hold_addr = '0;
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic rdy, input logic ack, input logic br, input logic [31:0] tgt);
    logic        req, vld, exp_req;
    logic [31:0] addr;
    pipeIFID_t   f;
    req  = instr_req;
    addr = instr_addr;
    vld  = fetch_vld;
    f    = fetch;

    exp_req = hold_pend ? 1'b1 : (occ < DEPTH);
    check("req", 32'(req), 32'(exp_req));
    check("vld", 32'(vld), 32'(occ != 0));
    if (hold_pend) check("addr_hold", addr, hold_addr);

    fetch_rdy     = rdy;
    instr_ack     = ack;
    instr_data    = ack ? mem_word(addr) : $urandom;
    branch        = br;
    branch_target = tgt;

    if (vld && rdy) begin
      check("pop_pc", f.pc, exp_pc);
      check("pop_ir", f.ir, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      occ--;
      pops++;
    end
    if (req && ack) begin
      if (!br && !stale) begin
        check("ack_addr", addr, fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
        occ++;
      end
      stale = 0;
    end
    hold_pend = req && !ack;
    hold_addr = addr;
    if (br) begin
      occ      = 0;
      exp_pc   = tgt & ~32'h3;
      fetch_pc = tgt & ~32'h3;
      stale    = req && !ack;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic zw(input int n, input logic rdy);
    repeat (n) step(rdy, instr_req, 1'b0, '0);
  endtask

  // Reset for a few cycles with a stray ack on the bus, then release.
  task automatic do_reset(input int cycles);
    rst        = 1'b1;
    instr_ack  = 1'b1;
    instr_data = $urandom;
    fetch_rdy  = 1'b1;
    branch     = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_req", 32'(instr_req), 32'(0));
    check("rst_addr", instr_addr, BOOT);
    check("rst_vld", 32'(fetch_vld), 32'(0));
    check("rst_fetch_pc", fetch.pc, 32'h0);
    check("rst_fetch_ir", fetch.ir, 32'h0);
    rst       = 1'b0;
    instr_ack = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(instr_req), 32'(1));
    check("first_addr", instr_addr, BOOT);
  endtask

  initial begin
    int  p0;
    bit  ok;
    rst           = 1'b1;
    instr_ack     = 1'b0;
    instr_data    = '0;
    branch        = 1'b0;
    branch_target = '0;
    fetch_rdy     = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Streaming from BOOT with zero-wait acks.
    zw(3, 1'b1);
    p0 = pops;
    zw(10, 1'b1);
    check("throughput", 32'(pops - p0), 32'((DEPTH == 2) ? 10 : 5));

    // Downstream stall, then release.
    zw(10, 1'b0);
    check("stall_req", 32'(instr_req), 32'(0));
    check("stall_vld", 32'(fetch_vld), 32'(1));
    zw(12, 1'b1);

    // Slow ack with a redirect while it is outstanding.
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (instr_req && !fetch_vld) begin ok = 1; break; end
      step(1'b1, 1'b0, 1'b0, '0);
    end
    check("idle_req_found", 32'(ok), 32'(1));
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("redir_req", 32'(instr_req), 32'(1));
    check("redir_addr", instr_addr, 32'h200);
    check("redir_vld", 32'(fetch_vld), 32'(0));
    zw(8, 1'b1);

    // Redirect coinciding with an ack (and a pop when the buffer allows it).
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_req && (fetch_vld || DEPTH == 1)) begin ok = 1; break; end
      step(1'b1, instr_req, 1'b0, '0);
    end
    check("ack_pop_found", 32'(ok), 32'(1));
    step(1'b1, 1'b1, 1'b1, 32'h300);
    check("br_ack_vld", 32'(fetch_vld), 32'(0));
    check("br_ack_req", 32'(instr_req), 32'(1));
    check("br_ack_addr", instr_addr, 32'h300);
    zw(6, 1'b1);

    // Address wrap at the top of memory.
    step(1'b1, instr_req, 1'b1, 32'hFFFF_FFF8);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_req && instr_addr == 32'hFFFF_FFFC) begin ok = 1; break; end
      step(1'b1, instr_req, 1'b0, '0);
    end
    check("wrap_found", 32'(ok), 32'(1));
    step(1'b1, 1'b1, 1'b0, '0);
    check("wrap_addr", instr_addr, 32'h0);
    zw(6, 1'b1);

    // Random traffic: stalls, slow acks, stray acks and redirects.
    p0 = pops;
    repeat (1500) begin
      logic r, a, b;
      r = ($urandom_range(9) < 7);
      a = instr_req ? 1'($urandom_range(1)) : ($urandom_range(3) == 0);
      b = ($urandom_range(31) == 0);
      step(r, a, b, $urandom);
    end
    check("progress", 32'(pops - p0 > 50), 32'(1));

    // Reset while a request is outstanding.
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_req) begin ok = 1; break; end
      step(1'b1, 1'b0, 1'b0, '0);
    end
    check("mid_req_found", 32'(ok), 32'(1));
    do_reset(2);
    zw(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kronos_fetch.md
# kronos_fetch

Instruction fetch stage of the Kronos core. Drives the instruction bus with a sequential PC, buffers returned words, and presents them downstream as a `pipeIFID_t` bundle under a valid/ready handshake to the decode stage. Accepts branch redirects from later stages: it flushes buffered instructions and drops any in-flight response.

## Interface
- `BOOT_ADDR`, default `32'h0`: PC of the first fetch after reset; bits [1:0] must be 0.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_addr`  out  32  fetch address; equals the internal PC register.
- `instr_req`  out  1  fetch request, registered.
- `instr_ack`  in  1  single-cycle response strobe; ignored while `instr_req`=0.
- `instr_data`  in  32  instruction word; valid only with `instr_ack`.
- `branch`  in  1  single-cycle redirect pulse.
- `branch_target`  in  32  redirect PC; bits [1:0] forced to 0.
- `fetch`  out  `pipeIFID_t`  {pc, ir} at the buffer head.
- `fetch_vld`  out  1  `fetch` holds a valid instruction.
- `fetch_rdy`  in  1  downstream accepts; pop when `fetch_vld & fetch_rdy`.

## Operation
- Buffer: FIFO of DEPTH entries of {pc, ir}. Occupancy `count` runs 0..DEPTH. `fetch_vld = (count != 0)`.
- Bus rules:
  - At most one outstanding request.
  - Once raised, `instr_req` and `instr_addr` hold until the ack cycle.
  - An ack may arrive in the first cycle of the request.
- Push on accepted ack: entry {pc, instr_data}. PC advances by 4, wrapping 32'hFFFF_FFFC to 32'h0.
- Request start rule: `instr_req` is set at an edge only if post-update `count < DEPTH`, no discard is pending, and there is no ack in progress with the buffer filling. Push happens only on ack, so count cannot grow while a request is outstanding, and overflow is impossible.
- At an ack edge, `instr_req` is re-registered with the same rule. It stays high continuously while space remains.
- Branch, which takes priority over push and pop in the same cycle:
  - count←0, PC←target.
  - With a request outstanding and no ack this cycle: set `discard`. The old request completes, its data is dropped, and `discard` clears. The next cycle requests at target.
  - With an ack in the same cycle: data dropped, no discard. The next cycle requests at target.
  - With no request outstanding: request at target on the next cycle.
- Simultaneous push and pop: count unchanged. The head advances and the new entry lands at the tail.
- Reset values:
  - `instr_req`=0, `instr_addr`=BOOT_ADDR.
  - `fetch_vld`=0, `fetch`=0.
  - count=0, discard=0.
- Reset mid-transaction abandons the request; a late ack is ignored because `instr_req`=0.

## Timing
- First `instr_req`=1 in the first cycle after `rst` deasserts.
- Ack at edge n → `fetch_vld`=1 in cycle n+1, with `fetch.pc` equal to the address acked.
- `fetch` is a register output; there is no combinational path from `instr_data`.
- `fetch_rdy` influences only the next-state logic.
- Branch at edge n → `fetch_vld`=0 in cycle n+1.
- Steady-state throughput with zero-wait acks and `fetch_rdy`=1:
  - DEPTH=2: 1 instruction per cycle.
  - DEPTH=1: 1 instruction per 2 cycles.

## Configuration
- `KRONOS_FETCH_PREFETCH_EN` defined: DEPTH=2, giving an output register plus a skid entry. Fetch runs back-to-back.
- `KRONOS_FETCH_PREFETCH_EN` undefined: DEPTH=1. A new request starts only after the single entry drains.
- Interface and ordering are identical in both builds.

## Structure
- `pipeIFID_t` and `FOUR` come from `kronos_types`.
- Add the depth constants `FETCH_DEPTH_MIN=1` and `FETCH_DEPTH_PF=2` to `kronos_types`.
- Sub-module `kronos_fetch_buffer`:
  - parameterised DEPTH FIFO of `pipeIFID_t`
  - ports: push, pop, flush, count, head
- The top module holds PC, request/discard state and the redirect logic.

## Test plan
- Reset with BOOT_ADDR=32'h100, zero-wait acks, `fetch_rdy`=1 → `fetch.pc` sequence 0x100, 0x104, 0x108. Every cycle with PREFETCH_EN, every other cycle without.
- `fetch_rdy`=0 held for 10 cycles → `instr_req` falls once count=DEPTH; no acks lost. Release → in-order delivery resumes at the next PC.
- Ack delayed 3 cycles, `branch` to 32'h200 in the second wait cycle → old data discarded. Next request is 0x200, and the first `fetch.pc`=0x200.
- `branch` in the same cycle as an ack and a pop → buffer empty next cycle. The acked word is never presented, and the request goes to target.
- PC 32'hFFFF_FFFC fetched → next `instr_addr`=32'h0.
- `rst` asserted mid-request, ack arriving during reset → after release, `instr_addr`=BOOT_ADDR, `fetch_vld`=0, and the first fetched word is from BOOT_ADDR.
